// File: rtl/cordic_rr_scheduler.sv
// Round-robin issue of NUM_CH phase requests into one shared, stall-free CORDIC.
// Define CORDIC_SCHED_CH0_PRIO_EN to give channel 0 absolute priority.
module cordic_rr_scheduler #(
    parameter  int NUM_CH     = 4,
    parameter  int ARG_WIDTH  = 16,
    parameter  int DAT_WIDTH  = 14,
    parameter  int CORDIC_LAT = 14,
    localparam int TAG_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_CH-1:0]           req_valid,
    output logic [NUM_CH-1:0]           req_ready,
    input  logic [NUM_CH*ARG_WIDTH-1:0] req_arg,
    output logic [ARG_WIDTH-1:0]        cordic_arg,
    input  logic [DAT_WIDTH-1:0]        cordic_re,
    input  logic [DAT_WIDTH-1:0]        cordic_im,
    output logic                        res_valid,
    output logic [TAG_W-1:0]            res_ch,
    output logic [DAT_WIDTH-1:0]        res_re,
    output logic [DAT_WIDTH-1:0]        res_im,
    output logic                        busy
);

    // Stage 0 pairs with cordic_arg; the last stage lines up with cordic_re/im.
    localparam int PIPE_N = CORDIC_LAT + 2;

    logic [TAG_W-1:0]     r_ptr;
    logic [ARG_WIDTH-1:0] r_arg;
    logic [PIPE_N-1:0]    r_vld;
    logic [TAG_W-1:0]     r_tag [PIPE_N];
    logic                 r_res_valid;
    logic [TAG_W-1:0]     r_res_ch;
    logic [DAT_WIDTH-1:0] r_res_re;
    logic [DAT_WIDTH-1:0] r_res_im;

    logic [NUM_CH-1:0]    w_gnt;
    logic [TAG_W-1:0]     w_gnt_idx;
    logic                 w_xfer;
    logic                 w_adv;
    logic [ARG_WIDTH-1:0] w_arg;
    logic [TAG_W-1:0]     w_ptr_nxt;
    int                   w_scan;

    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_xfer    = 1'b0;
        w_adv     = 1'b0;
        w_scan    = 0;
        if (en && !rst) begin
`ifdef CORDIC_SCHED_CH0_PRIO_EN
            if (req_valid[0]) begin
                w_xfer = 1'b1;
            end
`endif
            for (int k = 0; k < NUM_CH; k++) begin
                w_scan = int'(r_ptr) + k;
                if (w_scan >= NUM_CH) begin
                    w_scan = w_scan - NUM_CH;
                end
                if (!w_xfer && req_valid[w_scan]) begin
                    w_xfer    = 1'b1;
                    w_adv     = 1'b1;
                    w_gnt_idx = TAG_W'(w_scan);
                end
            end
            if (w_xfer) begin
                w_gnt[w_gnt_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_arg = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt_idx == TAG_W'(i)) begin
                w_arg = req_arg[i*ARG_WIDTH +: ARG_WIDTH];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == TAG_W'(NUM_CH - 1)) ?
                       '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_arg       <= '0;
            r_vld       <= '0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_re    <= '0;
            r_res_im    <= '0;
        end else begin
            r_vld       <= {r_vld[PIPE_N-2:0], w_xfer};
            r_res_valid <= r_vld[PIPE_N-1];
            if (w_xfer) begin
                r_arg <= w_arg;
            end
            if (w_adv) begin
                r_ptr <= w_ptr_nxt;
            end
            if (r_vld[PIPE_N-1]) begin
                r_res_ch <= r_tag[PIPE_N-1];
                r_res_re <= cordic_re;
                r_res_im <= cordic_im;
            end
        end
    end

    // Tag contents are qualified by r_vld, so they need no reset.
    always_ff @(posedge clk) begin
        r_tag[0] <= w_gnt_idx;
        for (int s = 1; s < PIPE_N; s++) begin
            r_tag[s] <= r_tag[s-1];
        end
    end

    assign req_ready  = w_gnt;
    assign cordic_arg = r_arg;
    assign res_valid  = r_res_valid;
    assign res_ch     = r_res_ch;
    assign res_re     = r_res_re;
    assign res_im     = r_res_im;
    assign busy       = |r_vld;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: directed table, corner sequences, random traffic.
// A stand-in CORDIC maps each argument to distinct Re/Im after a fixed delay.
module tb_cordic_rr_scheduler;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 14;
    localparam int LAT = 14;
    localparam int RES_DLY = LAT + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_arg;
    logic [AW-1:0]   cordic_arg;
    logic [DW-1:0]   cordic_re;
    logic [DW-1:0]   cordic_im;
    logic            res_valid;
    logic [1:0]      res_ch;
    logic [DW-1:0]   res_re;
    logic [DW-1:0]   res_im;
    logic            busy;

    cordic_rr_scheduler #(
        .NUM_CH(N), .ARG_WIDTH(AW), .DAT_WIDTH(DW), .CORDIC_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_arg(req_arg),
        .cordic_arg(cordic_arg), .cordic_re(cordic_re), .cordic_im(cordic_im),
        .res_valid(res_valid), .res_ch(res_ch),
        .res_re(res_re), .res_im(res_im), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] f_re(input logic [AW-1:0] a);
        return a[13:0] ^ 14'h1555;
    endfunction

    function automatic logic [DW-1:0] f_im(input logic [AW-1:0] a);
        return {a[1:0], a[15:4]};
    endfunction

    // Stand-in CORDIC: samples cordic_arg, output updates LAT edges later.
    logic [AW-1:0] cpipe [LAT+1];
    always @(posedge clk) begin
        cpipe[0] <= cordic_arg;
        for (int k = 1; k <= LAT; k++) cpipe[k] <= cpipe[k-1];
    end
    assign cordic_re = f_re(cpipe[LAT]);
    assign cordic_im = f_im(cpipe[LAT]);

    typedef struct {
        int            ch;
        logic [AW-1:0] arg;
        int            due;
    } item_t;

    item_t q[$];
    int    ptr;
    int    cyc;
    int    last_gnt;
    int    errors;
    int    checks;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // One clock: check grant before the edge, registered outputs after it.
    task automatic tick();
        int            eg;
        logic [N-1:0]  exp_rdy;
        logic [AW-1:0] garg;
        item_t         it;
        #1;
        eg   = -1;
        garg = '0;
        if (en && !rst) begin
`ifdef CORDIC_SCHED_CH0_PRIO_EN
            if (req_valid[0]) eg = 0;
`endif
            for (int k = 0; k < N; k++)
                if (eg < 0 && req_valid[(ptr + k) % N]) eg = (ptr + k) % N;
        end
        exp_rdy = (eg >= 0) ? N'(1 << eg) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (eg >= 0) garg = req_arg[eg*AW +: AW];
        last_gnt = eg;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            ptr = 0;
        end else if (eg >= 0) begin
            it.ch  = eg;
            it.arg = garg;
            it.due = cyc + RES_DLY;
            q.push_back(it);
`ifdef CORDIC_SCHED_CH0_PRIO_EN
            if (eg != 0) ptr = (eg + 1) % N;
`else
            ptr = (eg + 1) % N;
`endif
        end
        #1;
        if (rst) begin
            check("rst_res_valid", 32'(res_valid), 32'd0);
            check("rst_res_ch", 32'(res_ch), 32'd0);
            check("rst_res_re", 32'(res_re), 32'd0);
            check("rst_res_im", 32'(res_im), 32'd0);
            check("rst_cordic_arg", 32'(cordic_arg), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                it = q.pop_front();
                check("res_valid", 32'(res_valid), 32'd1);
                check("res_ch", 32'(res_ch), 32'(it.ch));
                check("res_re", 32'(res_re), 32'(f_re(it.arg)));
                check("res_im", 32'(res_im), 32'(f_im(it.arg)));
            end else begin
                check("res_valid_idle", 32'(res_valid), 32'd0);
            end
            check("busy", 32'(busy), 32'(q.size() > 0));
            if (eg >= 0) check("cordic_arg", 32'(cordic_arg), 32'(garg));
        end
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        en        = 1'b1;
        req_valid = '0;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic         en;
        logic [N-1:0] vld;
        logic [N-1:0] rdy_rr;
        logic [N-1:0] rdy_pr;
    } vec_t;

    vec_t          tbl[12];
    logic [N-1:0]  exp_v;
    int            gseq[12];
    logic          pend[N];
    logic [AW-1:0] parg[N];

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        ptr      = 0;
        last_gnt = -1;
        req_arg  = '0;
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0100, 4'b0100, 4'b0100};
        tbl[2]  = '{1'b1, 4'b1001, 4'b1000, 4'b0001};
        tbl[3]  = '{1'b1, 4'b1001, 4'b0001, 4'b0001};
        tbl[4]  = '{1'b1, 4'b1001, 4'b1000, 4'b0001};
        tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b1, 4'b1111, 4'b0001, 4'b0001};
        tbl[7]  = '{1'b1, 4'b1111, 4'b0010, 4'b0001};
        tbl[8]  = '{1'b1, 4'b0011, 4'b0001, 4'b0001};
        tbl[9]  = '{1'b1, 4'b0110, 4'b0010, 4'b0010};
        tbl[10] = '{1'b1, 4'b0010, 4'b0010, 4'b0010};
        tbl[11] = '{1'b1, 4'b0001, 4'b0001, 4'b0001};

        // Directed grant table from a fresh reset
        do_reset(2);
        for (int r = 0; r < 12; r++) begin
            en        = tbl[r].en;
            req_valid = tbl[r].vld;
            for (int c = 0; c < N; c++) req_arg[c*AW +: AW] = AW'($urandom);
            #1;
`ifdef CORDIC_SCHED_CH0_PRIO_EN
            exp_v = tbl[r].rdy_pr;
`else
            exp_v = tbl[r].rdy_rr;
`endif
            check("table_ready", 32'(req_ready), 32'(exp_v));
            tick();
        end
        en = 1'b1;
        idle(RES_DLY + 4);

        // Single ch2 request
        do_reset(2);
        req_arg[2*AW +: AW] = 16'h2000;
        req_valid = 4'b0100;
        tick();
        check("single_gnt", 32'(last_gnt), 32'd2);
        idle(RES_DLY + 4);

`ifndef CORDIC_SCHED_CH0_PRIO_EN
        // Fairness: everyone requesting for 12 cycles
        do_reset(1);
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < N; c++) req_arg[c*AW +: AW] = AW'($urandom);
            tick();
            gseq[i] = last_gnt;
        end
        for (int i = 0; i < 12; i++) check("fair_order", 32'(gseq[i]), 32'(i % 4));
        idle(RES_DLY + 4);
`else
        // Channel 0 priority over channel 1
        do_reset(1);
        req_valid = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("prio_ch0", 32'(last_gnt), 32'd0);
        end
        req_valid = 4'b0010;
        tick();
        check("prio_ch1_after", 32'(last_gnt), 32'd1);
        idle(RES_DLY + 4);
`endif

        // en low with requests pending: pipe drains, no issues
        do_reset(1);
        req_valid = '1;
        for (int i = 0; i < 3; i++) tick();
        en = 1'b0;
        for (int i = 0; i < RES_DLY + 6; i++) tick();
        check("en_drained_busy", 32'(busy), 32'd0);
        en = 1'b1;
        idle(2);

        // Reset mid-flight discards everything in the pipe
        do_reset(1);
        req_valid = '1;
        for (int i = 0; i < 5; i++) tick();
        idle(5);
        do_reset(1);
        idle(RES_DLY + 4);
        req_arg[1*AW +: AW] = 16'h1234;
        req_valid = 4'b0010;
        tick();
        check("post_rst_gnt", 32'(last_gnt), 32'd1);
        idle(RES_DLY + 4);

        // Random traffic honouring the hold-until-granted protocol
        do_reset(1);
        for (int c = 0; c < N; c++) pend[c] = 1'b0;
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && $urandom_range(0, 9) < 4) begin
                    pend[c] = 1'b1;
                    parg[c] = AW'($urandom);
                end
                req_valid[c]        = pend[c];
                req_arg[c*AW +: AW] = pend[c] ? parg[c] : AW'($urandom);
            end
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
            if (last_gnt >= 0) pend[last_gnt] = 1'b0;
        end
        rst = 1'b0;
        en  = 1'b1;
        idle(RES_DLY + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
